// File: rtl/range_session_arbiter.sv
// Session arbiter for a shared range-finder engine.
// Round-robin grants whole requester sessions (first beat through last beat),
// drives the engine's go/finish/data inputs, and returns the captured range
// tagged with the requester id. Stalled sessions time out and are drained.
module range_session_arbiter #(
  parameter  int WIDTH   = 8,
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 16,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  eng_go,
  output logic                  eng_finish,
  output logic [WIDTH-1:0]      eng_data,
  input  logic [WIDTH-1:0]      eng_range,
  input  logic                  eng_error,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic [WIDTH-1:0]      res_range,
  output logic [1:0]            res_code
);

  // Stall counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CLOSE,
    S_RESULT,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              err_q, err_d;
  logic              drain_q, drain_d;
  logic              res_valid_q, res_valid_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [WIDTH-1:0]  res_range_q, res_range_d;
  logic [1:0]        res_code_q, res_code_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   cand;
  logic [WIDTH-1:0]  pick_data;
  logic              pick_last;
  logic              g_valid;
  logic [WIDTH-1:0]  g_data;
  logic              g_last;
  logic              capture;
  logic              timed_out;

  // (p + k) mod NREQ without requiring NREQ to be a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return ID_W'(s);
  endfunction

  // Engine error outranks timeout; both outrank a clean finish.
  function automatic logic [1:0] result_code(input logic err, input logic tmo);
    if (err)      return 2'b10;
    else if (tmo) return 2'b01;
    else          return 2'b00;
  endfunction

  // Round-robin search starting at rr_ptr for the first valid requester.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign pick_data = req_data[pick_id*WIDTH +: WIDTH];
  assign pick_last = req_last[pick_id];
  assign g_valid   = req_valid[gnt_q];
  assign g_data    = req_data[gnt_q*WIDTH +: WIDTH];
  assign g_last    = req_last[gnt_q];

  // Session FSM: next state, engine drive, requester ready and result capture.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    hold_d      = hold_q;
    stall_d     = stall_q;
    err_d       = err_q;
    drain_d     = drain_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_range_d = res_range_q;
    res_code_d  = res_code_q;
    req_ready   = '0;
    eng_go      = 1'b0;
    eng_finish  = 1'b0;
    eng_data    = '0;
    capture     = 1'b0;
    timed_out   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          req_ready[pick_id] = 1'b1;
          eng_go   = 1'b1;
          eng_data = pick_data;
          gnt_d    = pick_id;
          hold_d   = pick_data;
          stall_d  = '0;
          err_d    = eng_error;
          state_d  = pick_last ? S_CLOSE : S_RUN;
        end
      end

      S_RUN: begin
        err_d = err_q | eng_error;
        if (g_valid) begin
          req_ready[gnt_q] = 1'b1;
          eng_data = g_data;
          hold_d   = g_data;
          stall_d  = '0;
          if (g_last) begin
            eng_finish = 1'b1;
            capture    = 1'b1;
          end
        end else if (stall_q == STALL_LAST) begin
          // Abort: finish on the held sample so min/max stay unchanged.
          eng_finish = 1'b1;
          eng_data   = hold_q;
          capture    = 1'b1;
          timed_out  = 1'b1;
          drain_d    = 1'b1;
        end else begin
          req_ready[gnt_q] = 1'b1;
          eng_data = hold_q;
          stall_d  = stall_q + CNT_W'(1);
        end
      end

      // One-sample session: finish cannot share the go cycle, so repeat the sample.
      S_CLOSE: begin
        err_d      = err_q | eng_error;
        eng_finish = 1'b1;
        eng_data   = hold_q;
        capture    = 1'b1;
      end

      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = wrap_add(gnt_q, 1);
          state_d     = drain_q ? S_DRAIN : S_IDLE;
        end
      end

      // Swallow the rest of a timed-out session without touching the engine.
      S_DRAIN: begin
        req_ready[gnt_q] = 1'b1;
        if (g_valid && g_last) begin
          drain_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      res_valid_d = 1'b1;
      res_id_d    = gnt_q;
      res_range_d = eng_range;
      res_code_d  = result_code(err_q | eng_error, timed_out);
      state_d     = S_RESULT;
    end
  end

  // State and result registers; reset abandons any session in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      hold_q      <= '0;
      stall_q     <= '0;
      err_q       <= 1'b0;
      drain_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_range_q <= '0;
      res_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      hold_q      <= hold_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      drain_q     <= drain_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_range_q <= res_range_d;
      res_code_q  <= res_code_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_range = res_range_q;
  assign res_code  = res_code_q;

endmodule

// File: tb/tb_range_session_arbiter.sv
// Testbench for range_session_arbiter with a small min/max range-finder model.
module tb_range_session_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        eng_go;
  logic        eng_finish;
  logic [7:0]  eng_data;
  logic [7:0]  eng_range;
  logic        eng_error;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [7:0]  res_range;
  logic [1:0]  res_code;

  range_session_arbiter #(.WIDTH(8), .NREQ(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .eng_go(eng_go), .eng_finish(eng_finish), .eng_data(eng_data),
    .eng_range(eng_range), .eng_error(eng_error),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_range(res_range), .res_code(res_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Range-finder model: tracks min/max from go; range = max - min in the finish cycle.
  logic       run_q;
  logic [7:0] mn_q, mx_q, lo, hi;
  always_ff @(posedge clock) begin
    if (reset) begin
      run_q <= 1'b0; mn_q <= 8'd0; mx_q <= 8'd0;
    end else if (eng_go) begin
      run_q <= 1'b1; mn_q <= eng_data; mx_q <= eng_data;
    end else if (eng_finish) begin
      run_q <= 1'b0;
    end else if (run_q) begin
      if (eng_data < mn_q) mn_q <= eng_data;
      if (eng_data > mx_q) mx_q <= eng_data;
    end
  end
  always_comb begin
    lo = (eng_data < mn_q) ? eng_data : mn_q;
    hi = (eng_data > mx_q) ? eng_data : mx_q;
    eng_range = run_q ? (hi - lo) : 8'd0;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 4'b0; req_last = 4'b0; req_data = 32'h0;
    res_ready = 1'b1; eng_error = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_for_go(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (eng_go === 1'b1) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic wait_for_res(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (res_valid === 1'b1) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic [3:0]  x_rdy;
    logic        x_go;
    logic        x_fin;
    logic [7:0]  x_dat;
    logic        x_rv;
    logic [1:0]  x_id;
    logic [7:0]  x_rng;
    logic [1:0]  x_code;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Four-beat session on req0, then a one-sample session on req2.
    vecs[0] = '{4'b0001, 32'h0000_0005, 4'b0000, 4'b0001, 1, 0, 8'h05, 0, 2'd0, 8'd0, 2'd0};
    vecs[1] = '{4'b0001, 32'h0000_0009, 4'b0000, 4'b0001, 0, 0, 8'h09, 0, 2'd0, 8'd0, 2'd0};
    vecs[2] = '{4'b0001, 32'h0000_0002, 4'b0000, 4'b0001, 0, 0, 8'h02, 0, 2'd0, 8'd0, 2'd0};
    vecs[3] = '{4'b0001, 32'h0000_0007, 4'b0001, 4'b0001, 0, 1, 8'h07, 0, 2'd0, 8'd0, 2'd0};
    vecs[4] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 0, 8'h00, 1, 2'd0, 8'd7, 2'd0};
    vecs[5] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 2'd0, 8'd0, 2'd0};
    vecs[6] = '{4'b0100, 32'h0040_0000, 4'b0100, 4'b0100, 1, 0, 8'h40, 0, 2'd0, 8'd0, 2'd0};
    vecs[7] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 1, 8'h40, 0, 2'd0, 8'd0, 2'd0};
    vecs[8] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 0, 8'h00, 1, 2'd2, 8'd0, 2'd0};
    vecs[9] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 2'd0, 8'd0, 2'd0};

    // Reset state
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clock);
    chk("reset_res", {res_valid, res_id, res_range, res_code}, 32'h0);
    chk("reset_eng", {req_ready, eng_go, eng_finish, eng_data}, 32'h0);
    tick();
    reset = 1'b0;

    // Table-driven sessions
    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].v; req_data = vecs[i].d; req_last = vecs[i].l;
      @(negedge clock);
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].x_rdy);
      chk($sformatf("vec%0d_go_fin", i), {eng_go, eng_finish}, {vecs[i].x_go, vecs[i].x_fin});
      chk($sformatf("vec%0d_data", i), eng_data, vecs[i].x_dat);
      chk($sformatf("vec%0d_res_valid", i), res_valid, vecs[i].x_rv);
      if (vecs[i].x_rv)
        chk($sformatf("vec%0d_result", i), {res_id, res_range, res_code},
            {vecs[i].x_id, vecs[i].x_rng, vecs[i].x_code});
      tick();
    end

    // Round-robin with all requesters valid: one-sample sessions 0,1,2,3,0
    do_reset();
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h4433_2211;
    for (int s = 0; s < 5; s++) begin
      int e;
      e = s % 4;
      wait_for_go(ok);
      chk($sformatf("rr%0d_go_seen", s), ok, 1);
      chk($sformatf("rr%0d_grant", s), req_ready, 32'(1 << e));
      chk($sformatf("rr%0d_data", s), eng_data, 32'(8'h11 * (e + 1)));
      tick();
      wait_for_res(ok);
      chk($sformatf("rr%0d_res_seen", s), ok, 1);
      chk($sformatf("rr%0d_res", s), {res_id, res_range, res_code}, {2'(e), 8'd0, 2'd0});
      tick();
    end

    // Stall of 15 cycles: no timeout, eng_data holds the last sample
    do_reset();
    req_valid = 4'b0010; req_data = 32'h0000_0300;
    @(negedge clock);
    chk("stall_go", {eng_go, req_ready, eng_data}, {1'b1, 4'b0010, 8'h03});
    tick();
    req_data = 32'h0000_0A00;
    @(negedge clock);
    chk("stall_beat2", {eng_go, eng_data}, {1'b0, 8'h0A});
    tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      chk($sformatf("stall15_c%0d", c), {req_ready, eng_finish, eng_data}, {4'b0010, 1'b0, 8'h0A});
      tick();
    end
    req_valid = 4'b0010; req_data = 32'h0000_0100; req_last = 4'b0010;
    @(negedge clock);
    chk("stall_last", {eng_finish, eng_data}, {1'b1, 8'h01});
    tick();
    idle_inputs();
    @(negedge clock);
    chk("stall_res", {res_valid, res_id, res_range, res_code}, {1'b1, 2'd1, 8'd9, 2'd0});
    tick();

    // Stall of 16 cycles: timeout, backpressure, then drain
    req_valid = 4'b0010; req_data = 32'h0000_0300;
    @(negedge clock);
    chk("tmo_go", {eng_go, req_ready}, {1'b1, 4'b0010});
    tick();
    req_data = 32'h0000_0A00;
    tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      chk($sformatf("tmo_stall_c%0d", c), {req_ready, eng_finish}, {4'b0010, 1'b0});
      tick();
    end
    @(negedge clock);
    chk("tmo_cycle", {req_ready, eng_finish, eng_data}, {4'b0000, 1'b1, 8'h0A});
    tick();
    res_ready = 1'b0;
    req_valid = 4'b0011; req_data = 32'h0000_04AA;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk($sformatf("bp_c%0d_eng", c), {req_ready, eng_go, eng_finish}, 32'h0);
      chk($sformatf("bp_c%0d_res", c), {res_valid, res_id, res_range, res_code}, {1'b1, 2'd1, 8'd7, 2'd1});
      tick();
    end
    res_ready = 1'b1;
    @(negedge clock);
    chk("bp_release", res_valid, 1);
    tick();
    req_data = 32'h0000_04AA;
    @(negedge clock);
    chk("drain_beat1", {req_ready, eng_go, eng_finish, eng_data}, {4'b0010, 1'b0, 1'b0, 8'h00});
    tick();
    req_data = 32'h0000_05AA; req_last = 4'b0010;
    @(negedge clock);
    chk("drain_last", {req_ready, eng_go, eng_finish, eng_data}, {4'b0010, 1'b0, 1'b0, 8'h00});
    tick();
    idle_inputs();
    @(negedge clock);
    chk("drain_done_idle", {req_ready, eng_go, eng_finish, res_valid}, 32'h0);
    tick();

    // Mid-session reset (rr_ptr is 2 here): session dropped, rr_ptr back to 0
    req_valid = 4'b0100; req_data = 32'h0020_0000;
    @(negedge clock);
    chk("mrst_go", {eng_go, req_ready}, {1'b1, 4'b0100});
    tick();
    req_data = 32'h0021_0000;
    tick();
    reset = 1'b1;
    req_valid = 4'b0000;
    tick();
    @(negedge clock);
    chk("mrst_outputs", {req_ready, eng_go, eng_finish, eng_data, res_valid}, 32'h0);
    tick();
    reset = 1'b0;
    req_valid = 4'b1001; req_last = 4'b1001; req_data = 32'h6600_0055;
    @(negedge clock);
    chk("mrst_rr_zero", {req_ready, eng_data}, {4'b0001, 8'h55});
    tick();
    idle_inputs();
    wait_for_res(ok);
    chk("mrst_res_seen", ok, 1);
    chk("mrst_res", {res_id, res_range, res_code}, {2'd0, 8'd0, 2'd0});
    tick();

    // Engine error mid-session on req3
    req_valid = 4'b1000; req_data = 32'h0200_0000;
    @(negedge clock);
    chk("err_go", {eng_go, req_ready}, {1'b1, 4'b1000});
    tick();
    req_data = 32'h0800_0000; eng_error = 1'b1;
    tick();
    eng_error = 1'b0; req_data = 32'h0400_0000; req_last = 4'b1000;
    @(negedge clock);
    chk("err_finish", {eng_finish, eng_data}, {1'b1, 8'h04});
    tick();
    idle_inputs();
    @(negedge clock);
    chk("err_res", {res_valid, res_id, res_range, res_code}, {1'b1, 2'd3, 8'd6, 2'd2});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
